dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words stored; power of two, minimum 4.
REQ-002 Parameter GNT_DELAY, default 0: extra cycles that data_req_i must stay high before grant; range 0-7.
REQ-003 Parameter RESP_LATENCY, default 1: cycles from the grant cycle to the response cycle; range 1-7.
REQ-004 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_ni  in  1  reset; asynchronous assert, active-low.
REQ-006 data_req_i  in  1  initiator request; addr/we/be/wdata are valid while high.
REQ-007 data_gnt_o  out  1  request accepted this cycle.
REQ-008 data_rvalid_o  out  1  response valid this cycle.
REQ-009 data_addr_i  in  32  byte address.
REQ-010 data_we_i  in  1  1 = write, 0 = read.
REQ-011 data_be_i  in  4  byte enables; bit i covers wdata[8i+7:8i].
REQ-012 data_wdata_i  in  32  write data.
REQ-013 data_rdata_o  out  32  read data, qualified by data_rvalid_o.
REQ-014 data_err_o  out  1  out-of-range access, qualified by data_rvalid_o.

Function
REQ-015 The block SHALL implement FSM states IDLE, WAIT and PEND.
- IDLE: no transaction outstanding.
- WAIT: request seen, grant delay still counting.
- PEND: granted, response not yet issued.
REQ-016 Grant timing:
- Count consecutive cycles with data_req_i high while the block is in IDLE or WAIT, or in the response cycle of the previous transaction.
- data_gnt_o SHALL be high, combinationally, in the cycle that count reaches GNT_DELAY+1.
REQ-017 With GNT_DELAY=0, data_gnt_o = data_req_i in any cycle where the block is able to accept.
REQ-018 If data_req_i drops during WAIT, the delay count SHALL clear and the block SHALL return to IDLE, with no grant and no side effects.
REQ-019 data_gnt_o SHALL be low during PEND except in the response cycle, so at most one transaction is outstanding.
REQ-020 Grant cycle N, read: the block SHALL sample addr/we/be and capture word mem[addr[log2(DEPTH_WORDS)+1:2]] at the end of cycle N.
REQ-020a Grant cycle N, write: it SHALL update only the bytes whose data_be_i bit is set, at the end of cycle N.
REQ-021 data_rvalid_o SHALL be high for exactly one cycle, cycle N+RESP_LATENCY, for both reads and writes.
REQ-022 In that cycle, a read SHALL drive the captured word on data_rdata_o and a write SHALL drive 0; data_rdata_o SHALL be 0 whenever data_rvalid_o is low.
REQ-023 Read data SHALL reflect writes granted in earlier cycles; reads ignore data_be_i and return the full word.
REQ-024 data_addr_i[1:0] SHALL be ignored (word-aligned access).
REQ-025 A write with data_be_i=4'b0000 SHALL modify no byte and SHALL still produce a response.
REQ-026 Out-of-range access (data_addr_i[31:2] >= DEPTH_WORDS):
- The block SHALL still grant and respond normally.
- Writes SHALL be dropped.
- Reads SHALL return 0.
- data_err_o SHALL be 1 in the response cycle; it SHALL be 0 in all other cycles.
REQ-027 Back-to-back: if the initiator holds data_req_i high in the response cycle of transaction k, transaction k+1 MAY be granted in that same cycle (GNT_DELAY=0), giving throughput of one transaction per RESP_LATENCY cycles.
REQ-028 A write granted in the response cycle of a read SHALL NOT alter the rdata driven in that cycle.

Reset
REQ-029 While rst_ni is low: FSM in IDLE, counters 0, data_gnt_o=0, data_rvalid_o=0, data_rdata_o=0, data_err_o=0.
REQ-030 Memory contents SHALL NOT be reset.
REQ-031 Reset asserted mid-transaction (WAIT or PEND) SHALL discard it; no rvalid SHALL appear for it after reset releases.
REQ-032 The first grant after reset release SHALL follow REQ-016 timing, counted from the first cycle after release.

Verification
REQ-033 GNT_DELAY=0, RESP_LATENCY=1:
- Stimulus: write addr 0x10, wdata 0xDEADBEEF, be 4'hF, then read 0x10.
- Response: gnt in each req cycle; rvalid one cycle later; read rdata 0xDEADBEEF, err 0.
REQ-034 Partial write over 0xDEADBEEF:
- Stimulus: write be 4'b0101, wdata 0x11223344, then read.
- Response: rdata 0xDE22BE44.
REQ-035 GNT_DELAY=2, RESP_LATENCY=3:
- Stimulus: req held high from cycle 0.
- Response: gnt in cycle 2, rvalid in cycle 5.
- Stimulus: req dropped in cycle 1.
- Response: no gnt, no rvalid, memory unchanged.
REQ-036 DEPTH_WORDS=1024:
- Stimulus: read 0x1000.
- Response: rvalid with rdata 0, err 1.
- Stimulus: write 0x1000, then read 0x0.
- Response: word 0 unchanged.
REQ-037 Back-to-back, RESP_LATENCY=1:
- Stimulus: 4 consecutive reads with req held high.
- Response: gnt every cycle, rvalid every cycle one cycle behind gnt, data in request order.
REQ-038 Reset mid-operation:
- Stimulus: rst_ni pulsed low during PEND with RESP_LATENCY=3.
- Response: all outputs 0 immediately; no rvalid after release; the next request is serviced normally.

Source files
------------

// File: rtl/dmem_responder.sv
// Single-port word memory behind an OBI-style req/gnt/rvalid data interface.
// Configurable grant delay and response latency; one transaction outstanding at most.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned GNT_DELAY    = 0,
  parameter int unsigned RESP_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic [1:0]  dbg_state_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_PEND = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      req_cnt_q, req_cnt_d;
  logic [2:0]      lat_cnt_q, lat_cnt_d;
  logic            resp_cycle;
  logic            can_accept;
  logic            gnt;
  logic            in_range;
  logic [AW-1:0]   word_idx;
  logic [31:0]     rdata_q;
  logic            is_read_q;
  logic            err_q;
  logic            unused_addr_lsb;
  logic [31:0]     mem [DEPTH_WORDS];

  // Handshake: a transaction transfers in a cycle where data_req_i && data_gnt_o;
  // its single response appears RESP_LATENCY cycles later with data_rvalid_o high.
  // The response cycle can itself accept the next request, giving back-to-back flow.
  assign resp_cycle = (state_q == S_PEND) && (lat_cnt_q == 3'(RESP_LATENCY));
  assign can_accept = (state_q != S_PEND) || resp_cycle;
  assign gnt        = rst_ni && data_req_i && can_accept && (req_cnt_q == 3'(GNT_DELAY));

  assign in_range        = {1'b0, data_addr_i[31:2]} < 31'(DEPTH_WORDS);
  assign word_idx        = data_addr_i[AW+1:2];
  assign unused_addr_lsb = ^data_addr_i[1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      req_cnt_q <= '0;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      req_cnt_q <= req_cnt_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  // The request counter only runs while a grant is possible; any gap clears it.
  always_comb begin
    state_d   = state_q;
    req_cnt_d = '0;
    lat_cnt_d = lat_cnt_q;
    if (state_q == S_PEND && !resp_cycle) begin
      lat_cnt_d = lat_cnt_q + 3'd1;
    end
    if (can_accept) begin
      if (gnt) begin
        state_d   = S_PEND;
        lat_cnt_d = 3'd1;
      end else if (data_req_i) begin
        state_d   = S_WAIT;
        req_cnt_d = req_cnt_q + 3'd1;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_comb begin
    data_gnt_o    = gnt;
    data_rvalid_o = resp_cycle;
    data_err_o    = resp_cycle && err_q;
    data_rdata_o  = (resp_cycle && is_read_q) ? rdata_q : '0;
    dbg_state_o   = state_q;
  end

  // Response payload is captured at grant so a later write cannot disturb it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q   <= '0;
      is_read_q <= 1'b0;
      err_q     <= 1'b0;
    end else if (gnt) begin
      is_read_q <= !data_we_i;
      err_q     <= !in_range;
      rdata_q   <= (!data_we_i && in_range) ? mem[word_idx] : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (gnt && data_we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) mem[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance 0 uses GNT_DELAY=0/RESP_LATENCY=1,
// instance 1 uses GNT_DELAY=2/RESP_LATENCY=3.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst0_n, rst1_n;
  logic        req_v   [2];
  logic        we_v    [2];
  logic [31:0] addr_v  [2];
  logic [3:0]  be_v    [2];
  logic [31:0] wdata_v [2];
  logic        gnt_v   [2];
  logic        rv_v    [2];
  logic [31:0] rdata_v [2];
  logic        err_v   [2];
  logic [1:0]  st_v    [2];

  logic        s_gnt, s_rv, s_err;
  logic [31:0] s_rdata;
  logic [1:0]  s_st;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] b2b_data [4] = '{32'h0BADF00D, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F};

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .GNT_DELAY(0), .RESP_LATENCY(1)) dut0 (
    .clk_i(clk), .rst_ni(rst0_n), .data_req_i(req_v[0]), .data_gnt_o(gnt_v[0]),
    .data_rvalid_o(rv_v[0]), .data_addr_i(addr_v[0]), .data_we_i(we_v[0]),
    .data_be_i(be_v[0]), .data_wdata_i(wdata_v[0]), .data_rdata_o(rdata_v[0]),
    .data_err_o(err_v[0]), .dbg_state_o(st_v[0])
  );

  dmem_responder #(.DEPTH_WORDS(1024), .GNT_DELAY(2), .RESP_LATENCY(3)) dut1 (
    .clk_i(clk), .rst_ni(rst1_n), .data_req_i(req_v[1]), .data_gnt_o(gnt_v[1]),
    .data_rvalid_o(rv_v[1]), .data_addr_i(addr_v[1]), .data_we_i(we_v[1]),
    .data_be_i(be_v[1]), .data_wdata_i(wdata_v[1]), .data_rdata_o(rdata_v[1]),
    .data_err_o(err_v[1]), .dbg_state_o(st_v[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sample(input int d);
    s_gnt   = gnt_v[d];
    s_rv    = rv_v[d];
    s_rdata = rdata_v[d];
    s_err   = err_v[d];
    s_st    = st_v[d];
  endtask

  // Drive one cycle on instance d at the falling edge, then sample its outputs.
  task automatic step(input int d, input logic req, input logic we, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wdata);
    @(negedge clk);
    req_v[d]   = req;
    we_v[d]    = we;
    addr_v[d]  = addr;
    be_v[d]    = be;
    wdata_v[d] = wdata;
    #1;
    sample(d);
  endtask

  task automatic idle(input int d);
    step(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic expect_out(input string tag, input logic g, input logic v,
                            input logic [31:0] rd, input logic e);
    check({tag, ".gnt_rv_err"}, {29'b0, s_gnt, s_rv, s_err}, {29'b0, g, v, e});
    check({tag, ".rdata"}, s_rdata, rd);
  endtask

  // Instance 1 transaction: req held for 'hold' cycles; grant expected in cycle 2
  // and response in cycle 5 only when hold reaches the grant delay.
  task automatic txn1(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input int hold, input logic [31:0] exp_rd);
    for (int c = 0; c < 6; c++) begin
      step(1, c < hold, we, addr, 4'hF, wdata);
      expect_out($sformatf("%s.c%0d", tag, c), (hold >= 3) && (c == 2),
                 (hold >= 3) && (c == 5), ((hold >= 3) && (c == 5)) ? exp_rd : 32'h0, 1'b0);
    end
  endtask

  initial begin
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_v[d] = 1'b0; we_v[d] = 1'b0; addr_v[d] = '0; be_v[d] = '0; wdata_v[d] = '0;
    end

    // Reset: outputs quiet even with a request present.
    step(0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    expect_out("rst0", 1'b0, 1'b0, 32'h0, 1'b0);
    check("rst0.state", {30'b0, s_st}, 32'd0);
    @(negedge clk);
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    req_v[0] = 1'b0;

    // Full write then read.
    step(0, 1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);  expect_out("wr10", 1, 0, 32'h0, 0);
    step(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);         expect_out("rd10", 1, 1, 32'h0, 0);
    idle(0);                                          expect_out("rd10.resp", 0, 1, 32'hDEADBEEF, 0);

    // Partial write, then misaligned read of the same word.
    step(0, 1'b1, 1'b1, 32'h10, 4'b0101, 32'h11223344); expect_out("pw", 1, 0, 32'h0, 0);
    idle(0);                                          expect_out("pw.resp", 0, 1, 32'h0, 0);
    step(0, 1'b1, 1'b0, 32'h13, 4'h0, 32'h0);         expect_out("pr13", 1, 0, 32'h0, 0);
    idle(0);                                          expect_out("pr13.resp", 0, 1, 32'hDE22BE44, 0);

    // Zero byte-enable write still responds and leaves data alone.
    step(0, 1'b1, 1'b1, 32'h10, 4'h0, 32'hFFFFFFFF);  expect_out("be0", 1, 0, 32'h0, 0);
    step(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);         expect_out("be0.resp", 1, 1, 32'h0, 0);
    idle(0);                                          expect_out("be0.rd", 0, 1, 32'hDE22BE44, 0);

    // Out-of-range read and write; word 0 must survive the dropped write.
    step(0, 1'b1, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D);   expect_out("w0", 1, 0, 32'h0, 0);
    step(0, 1'b1, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF); expect_out("oorw", 1, 1, 32'h0, 0);
    step(0, 1'b1, 1'b0, 32'h1000, 4'h0, 32'h0);       expect_out("oorr", 1, 1, 32'h0, 1);
    step(0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);          expect_out("oorr.resp", 1, 1, 32'h0, 1);
    idle(0);                                          expect_out("w0.rd", 0, 1, 32'hCAFEF00D, 0);
    idle(0);                                          expect_out("quiet", 0, 0, 32'h0, 0);

    // Write granted in a read's response cycle does not disturb that read.
    step(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);         expect_out("rw.r", 1, 0, 32'h0, 0);
    step(0, 1'b1, 1'b1, 32'h10, 4'hF, 32'h55667788);  expect_out("rw.w", 1, 1, 32'hDE22BE44, 0);
    step(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);         expect_out("rw.r2", 1, 1, 32'h0, 0);
    idle(0);                                          expect_out("rw.r2.resp", 0, 1, 32'h55667788, 0);

    // Back-to-back: fill four words, then four reads with req held high.
    for (int i = 0; i < 4; i++) begin
      step(0, 1'b1, 1'b1, 32'h20 + 32'(4 * i), 4'hF, b2b_data[i]);
      check($sformatf("b2b.wgnt%0d", i), {31'b0, s_gnt}, 32'd1);
    end
    idle(0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1'b1, 1'b0, 32'h20 + 32'(4 * i), 4'h0, 32'h0);
      check($sformatf("b2b.gnt%0d", i), {31'b0, s_gnt}, 32'd1);
      check($sformatf("b2b.rv%0d", i), {31'b0, s_rv}, {31'b0, i > 0});
      if (s_rv) begin
        if (exp_q.size() == 0) check("b2b.extra", 32'd1, 32'd0);
        else check($sformatf("b2b.rd%0d", i), s_rdata, exp_q.pop_front());
      end
      if (s_gnt) exp_q.push_back(b2b_data[i]);
    end
    idle(0);
    check("b2b.rv_last", {31'b0, s_rv}, 32'd1);
    if (s_rv && exp_q.size() > 0) check("b2b.rd_last", s_rdata, exp_q.pop_front());
    check("b2b.drain", 32'(exp_q.size()), 32'd0);

    // Instance 1: grant delay 2, response latency 3.
    txn1("d1.wr", 1'b1, 32'h40, 32'hA5A5A5A5, 3, 32'h0);
    txn1("d1.rd", 1'b0, 32'h40, 32'h0, 3, 32'hA5A5A5A5);
    txn1("d1.drop", 1'b1, 32'h40, 32'h0, 1, 32'h0);
    txn1("d1.rd2", 1'b0, 32'h40, 32'h0, 3, 32'hA5A5A5A5);

    // Reset pulsed while a read is pending; its response must never appear.
    for (int c = 0; c < 3; c++) step(1, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0);
    check("d1.rst.gnt", {31'b0, s_gnt}, 32'd1);
    @(negedge clk);
    rst1_n = 1'b0;
    #1;
    sample(1);
    expect_out("d1.rst.in", 0, 0, 32'h0, 0);
    check("d1.rst.state", {30'b0, s_st}, 32'd0);
    step(1, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0);
    expect_out("d1.rst.hold", 0, 0, 32'h0, 0);
    @(negedge clk);
    rst1_n = 1'b1;
    req_v[1] = 1'b0;
    #1;
    sample(1);
    expect_out("d1.rst.rel", 0, 0, 32'h0, 0);
    txn1("d1.after", 1'b0, 32'h40, 32'h0, 3, 32'hA5A5A5A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
